// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_pkg : shared constants for the instruction fetch path
// Rev 1.0
// ============================================================================
package instr_fetch_pkg;

  localparam int          INSTR_BYTES       = 4;
  localparam int          ADDR_LSB          = $clog2(INSTR_BYTES);
  localparam logic [15:0] DEFAULT_BOOT_ADDR = 16'h8000;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// prefetch_fifo : synchronous FIFO with flush and occupancy count
// Rev 1.0
// ============================================================================
module prefetch_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_buf.sv
`default_nettype none
// ============================================================================
// instr_prefetch_buf : instruction prefetcher with branch flush and buffer
// Rev 1.0
// ============================================================================
module instr_prefetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = ADDR_WIDTH'(DEFAULT_BOOT_ADDR)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fetch_en_i,
  input  logic                    branch_i,
  input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
  output logic                    instr_valid_o,
  input  logic                    instr_ready_i,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  output logic [ADDR_WIDTH-1:0]   instr_addr_o,
  output logic                    busy_o,
  output logic                    mem_en_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BOOT_ALIGNED =
    {BOOT_ADDR[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};

  logic [ADDR_WIDTH-1:0] fetch_addr_q,    fetch_addr_d;
  logic [ADDR_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic                  inflight_q,      inflight_d;

  logic [CNT_W-1:0]      w_count;
  logic [CNT_W:0]        w_occupancy;
  logic [FIFO_W-1:0]     w_head;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_branch_target;
  logic                  w_unused_addr_lsbs;

  assign w_branch_target    = {branch_addr_i[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign w_unused_addr_lsbs = ^branch_addr_i[ADDR_LSB-1:0];

  // A pop in the same cycle is deliberately not credited toward free space.
  assign w_occupancy = {1'b0, w_count} + (CNT_W+1)'(inflight_q);
  assign w_issue     = fetch_en_i & ~branch_i & rst_n &
                       (w_occupancy < (CNT_W+1)'(DEPTH));
  // A response landing in a branch cycle belongs to the old stream.
  assign w_push      = inflight_q & ~branch_i;
  assign w_pop       = instr_valid_o & instr_ready_i & ~branch_i;

  always_comb begin
    fetch_addr_d    = fetch_addr_q;
    inflight_d      = 1'b0;
    inflight_addr_d = inflight_addr_q;
    if (branch_i) begin
      fetch_addr_d = w_branch_target;
    end else if (w_issue) begin
      fetch_addr_d    = fetch_addr_q + ADDR_WIDTH'(INSTR_BYTES);
      inflight_d      = 1'b1;
      inflight_addr_d = fetch_addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q    <= BOOT_ALIGNED;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      fetch_addr_q    <= fetch_addr_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  prefetch_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (branch_i),
    .push_i  (w_push),
    .wdata_i ({mem_rdata_i, inflight_addr_q}),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .count_o (w_count)
  );

  assign instr_valid_o = (w_count != '0);
  // Head fields read as zero while empty so reset and idle look clean.
  assign instr_rdata_o = instr_valid_o ? w_head[FIFO_W-1:ADDR_WIDTH] : '0;
  assign instr_addr_o  = instr_valid_o ? w_head[ADDR_WIDTH-1:0]      : '0;
  assign busy_o        = inflight_q | instr_valid_o;

  assign mem_en_o   = w_issue;
  assign mem_addr_o = fetch_addr_q;
  assign mem_we_o   = 1'b0;
  assign mem_be_o   = '1;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buf.sv
`default_nettype none
// ============================================================================
// tb_instr_prefetch_buf : scoreboard bench for instr_prefetch_buf
// Rev 1.0
// ============================================================================
module tb_instr_prefetch_buf;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, fetch_en, branch, ready;
  logic [AW-1:0] branch_addr;
  logic          instr_valid, busy, mem_en, mem_we;
  logic [DW-1:0] instr_rdata, mem_rdata;
  logic [AW-1:0] instr_addr, mem_addr;
  logic [DW/8-1:0] mem_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW+AW-1:0] sb_q [$];
  logic [DW+AW-1:0] sb_exp;

  instr_prefetch_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .instr_valid_o (instr_valid),
    .instr_ready_i (ready),
    .instr_rdata_o (instr_rdata),
    .instr_addr_o  (instr_addr),
    .busy_o        (busy),
    .mem_en_o      (mem_en),
    .mem_addr_o    (mem_addr),
    .mem_we_o      (mem_we),
    .mem_be_o      (mem_be),
    .mem_rdata_i   (mem_rdata)
  );

  function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
    return {~a, a ^ 16'h5A3C};
  endfunction

  // Memory answers exactly one cycle after a request; garbage otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? mem_model(mem_addr) : 32'hDEAD_BEEF;

  // Scoreboard: push on issue, pop on handshake, drop on branch or reset.
  always @(negedge clk) begin
    if (!rst_n || branch) begin
      sb_q.delete();
    end else begin
      if (instr_valid && ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got addr %h data %h, required no instruction", instr_addr, instr_rdata);
        end else begin
          sb_exp = sb_q.pop_front();
          if ({instr_rdata, instr_addr} !== sb_exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h/%h, required %h/%h", instr_rdata, instr_addr, sb_exp[DW+AW-1:AW], sb_exp[AW-1:0]);
          end
        end
      end
      if (mem_en) sb_q.push_back({mem_model(mem_addr), mem_addr});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_en = 1'b0; branch = 1'b0; ready = 1'b0; branch_addr = '0;
    tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    fetch_en = 1'b1; ready = 1'b1;
    tick();
    n_checks++; if (mem_en !== 1'b0)      begin n_fail++; $display("FAIL rst_mem_en: got %b, required 0", mem_en); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", instr_valid); end
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
    n_checks++; if ({instr_rdata, instr_addr} !== '0) begin n_fail++; $display("FAIL rst_head: got %h/%h, required 0", instr_rdata, instr_addr); end
    n_checks++; if ({mem_we, mem_be} !== 5'b0_1111) begin n_fail++; $display("FAIL rst_we_be: got %b/%b, required 0/1111", mem_we, mem_be); end
  endtask

  task automatic test_startup();
    int streamed;
    rst_n = 1'b1;
    #1;
    n_checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h8000}) begin n_fail++; $display("FAIL start_c0: got %b/%h, required 1/8000", mem_en, mem_addr); end
    tick();
    n_checks++; if ({mem_en, mem_addr, instr_valid} !== {1'b1, 16'h8004, 1'b0}) begin n_fail++; $display("FAIL start_c1: got %b/%h/%b, required 1/8004/0", mem_en, mem_addr, instr_valid); end
    tick();
    n_checks++; if ({mem_en, mem_addr, instr_valid, instr_addr} !== {1'b1, 16'h8008, 1'b1, 16'h8000}) begin n_fail++; $display("FAIL start_c2: got %b/%h/%b/%h, required 1/8008/1/8000", mem_en, mem_addr, instr_valid, instr_addr); end
    streamed = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (instr_valid && mem_en) streamed++;
    end
    n_checks++; if (streamed !== 16) begin n_fail++; $display("FAIL back_to_back: got %0d, required 16", streamed); end
  endtask

  task automatic test_backpressure();
    int issues;
    do_reset();
    fetch_en = 1'b1; ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_en) issues++;
      tick();
    end
    n_checks++; if (issues !== 4) begin n_fail++; $display("FAIL bp_issues: got %0d, required 4", issues); end
    n_checks++; if ({mem_en, instr_valid, busy} !== 3'b011) begin n_fail++; $display("FAIL bp_full: got en/valid/busy %b%b%b, required 011", mem_en, instr_valid, busy); end
    ready = 1'b1;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL bp_pop_not_credited: got %b, required 0", mem_en); end
    tick();
    n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL bp_refill: got %b, required 1", mem_en); end
    repeat (8) tick();
  endtask

  task automatic test_branch();
    do_reset();
    fetch_en = 1'b1; ready = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    repeat (4) tick();
    branch = 1'b1; branch_addr = 16'h0123; ready = 1'b1;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL br_T_en: got %b, required 0", mem_en); end
    tick();
    branch = 1'b0;
    #1;
    n_checks++; if ({mem_en, mem_addr, instr_valid} !== {1'b1, 16'h0120, 1'b0}) begin n_fail++; $display("FAIL br_T1: got %b/%h/%b, required 1/0120/0", mem_en, mem_addr, instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_T2_valid: got %b, required 0", instr_valid); end
    tick();
    n_checks++; if ({instr_valid, instr_addr} !== {1'b1, 16'h0120}) begin n_fail++; $display("FAIL br_T3: got %b/%h, required 1/0120", instr_valid, instr_addr); end
    repeat (6) tick();
  endtask

  task automatic test_wrap();
    branch = 1'b1; branch_addr = 16'hFFFE;
    #1;
    tick();
    branch = 1'b0;
    #1;
    n_checks++; if ({mem_en, mem_addr} !== {1'b1, 16'hFFFC}) begin n_fail++; $display("FAIL wrap_first: got %b/%h, required 1/FFFC", mem_en, mem_addr); end
    tick();
    n_checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL wrap_second: got %b/%h, required 1/0000", mem_en, mem_addr); end
    tick();
    n_checks++; if ({instr_valid, instr_addr} !== {1'b1, 16'hFFFC}) begin n_fail++; $display("FAIL wrap_head: got %b/%h, required 1/FFFC", instr_valid, instr_addr); end
    repeat (6) tick();
  endtask

  task automatic test_fetch_disable();
    int pops, en_seen, cyc;
    fetch_en = 1'b0;
    #1;
    n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL dis_en_now: got %b, required 0", mem_en); end
    pops = 0; en_seen = 0; cyc = 0;
    do begin
      tick();
      cyc++;
      if (instr_valid) pops++;
      if (mem_en) en_seen++;
    end while (busy && cyc < 10);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy_timeout: got %b, required 0", busy); end
    n_checks++; if (pops !== 1) begin n_fail++; $display("FAIL dis_inflight_delivered: got %0d, required 1", pops); end
    n_checks++; if (en_seen !== 0) begin n_fail++; $display("FAIL dis_no_issue: got %0d, required 0", en_seen); end
    n_checks++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL dis_sb_drained: got %0d, required 0", sb_q.size()); end
  endtask

  task automatic test_reset_midop();
    fetch_en = 1'b1; ready = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    n_checks++; if ({mem_en, instr_valid, busy, instr_rdata, instr_addr} !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %b%b%b/%h/%h, required all 0", mem_en, instr_valid, busy, instr_rdata, instr_addr); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if ({mem_en, mem_addr} !== {1'b1, 16'h8000}) begin n_fail++; $display("FAIL midrst_restart: got %b/%h, required 1/8000", mem_en, mem_addr); end
    repeat (8) tick();
    fetch_en = 1'b0;
    repeat (4) tick();
    n_checks++; if ({busy, 32'(sb_q.size())} !== 33'd0) begin n_fail++; $display("FAIL midrst_drain: got busy %b left %0d, required 0/0", busy, sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_branch();
    test_wrap();
    test_fetch_disable();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
